// File: rtl/mesi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_pkg                                                             |
// | Line-state, bus-command and controller-state encodings.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    localparam logic [1:0] c_CMD_NONE   = 2'b00;
    localparam logic [1:0] c_CMD_BUSRD  = 2'b01;
    localparam logic [1:0] c_CMD_BUSRDX = 2'b10;
    localparam logic [1:0] c_CMD_WB     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_FILL = 3'd2,
        S_UPG  = 3'd3,
        S_RESP = 3'd4
    } fsm_t;

endpackage
`default_nettype wire

// File: rtl/mesi_line_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_line_array                                                      |
// | Direct-mapped tag/state store: processor and snoop read ports, one   |
// | controller write port plus a snoop state-update port.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mesi_line_array
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_pr_idx,
    output mesi_t            o_pr_state,
    output logic [TAG_W-1:0] o_pr_tag,
    input  logic [IDX_W-1:0] i_sn_idx,
    output mesi_t            o_sn_state,
    output logic [TAG_W-1:0] o_sn_tag,
    input  logic             i_ctl_we,
    input  logic [IDX_W-1:0] i_ctl_idx,
    input  mesi_t            i_ctl_state,
    input  logic             i_ctl_tag_we,
    input  logic [TAG_W-1:0] i_ctl_tag,
    input  logic             i_sn_we,
    input  mesi_t            i_sn_state
);

    mesi_t            r_state [NUM_LINES];
    logic [TAG_W-1:0] r_tag   [NUM_LINES];

    assign o_pr_state = r_state[i_pr_idx];
    assign o_pr_tag   = r_tag[i_pr_idx];
    assign o_sn_state = r_state[i_sn_idx];
    assign o_sn_tag   = r_tag[i_sn_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) r_state[i] <= MESI_I;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (i_ctl_we && i_ctl_idx == IDX_W'(i))
                    r_state[i] <= i_ctl_state;
                else if (i_sn_we && i_sn_idx == IDX_W'(i))
                    r_state[i] <= i_sn_state;
            end
        end
    end

    // Tags need no reset: a line in I never reports a hit.
    always_ff @(posedge clk) begin
        if (i_ctl_tag_we) r_tag[i_ctl_idx] <= i_ctl_tag;
    end

endmodule
`default_nettype wire

// File: rtl/mesi_multiline_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_multiline_controller                                            |
// | Direct-mapped MESI cache controller with snooping bus interface.     |
// | Option macro: MESI_UPGR_EN (write hit in S issues BusUpgr, cmd 11).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mesi_multiline_controller
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pr_valid,
    input  logic              pr_wr,
    input  logic [ADDR_W-1:0] pr_addr,
    output logic              pr_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_done,
    input  logic              shared_in,
    input  logic              snoop_valid,
    input  logic              snoop_rdx,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_shared,
    output logic              snoop_flush,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

`ifdef MESI_UPGR_EN
    localparam logic [1:0] c_UPG_CMD = c_CMD_WB;
`else
    localparam logic [1:0] c_UPG_CMD = c_CMD_BUSRDX;
`endif

    // Asserts immediately, releases two clocks after reset_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    fsm_t              r_fsm;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic              r_bus_req;
    logic [1:0]        r_bus_cmd;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_pr_ready;

    logic [IDX_W-1:0]  w_pr_idx, w_sn_idx, w_ctl_idx;
    logic [TAG_W-1:0]  w_pr_tag, w_sn_tag, w_pr_tag_q, w_sn_tag_q;
    mesi_t             w_pr_state, w_sn_state, w_ctl_state, w_sn_new;
    logic              w_pr_hit, w_sn_hit, w_accept, w_upg_kill;
    logic              w_ctl_we, w_tag_we, w_sn_we;

    assign w_pr_idx = pr_addr[IDX_W-1:0];
    assign w_pr_tag = pr_addr[ADDR_W-1:IDX_W];
    assign w_sn_idx = snoop_addr[IDX_W-1:0];
    assign w_sn_tag = snoop_addr[ADDR_W-1:IDX_W];

    mesi_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk          (clk),
        .rst_n        (w_rst_n),
        .i_pr_idx     (w_pr_idx),
        .o_pr_state   (w_pr_state),
        .o_pr_tag     (w_pr_tag_q),
        .i_sn_idx     (w_sn_idx),
        .o_sn_state   (w_sn_state),
        .o_sn_tag     (w_sn_tag_q),
        .i_ctl_we     (w_ctl_we),
        .i_ctl_idx    (w_ctl_idx),
        .i_ctl_state  (w_ctl_state),
        .i_ctl_tag_we (w_tag_we),
        .i_ctl_tag    (r_addr[ADDR_W-1:IDX_W]),
        .i_sn_we      (w_sn_we),
        .i_sn_state   (w_sn_new)
    );

    assign w_pr_hit     = (w_pr_state != MESI_I) && (w_pr_tag_q == w_pr_tag);
    assign w_sn_hit     = snoop_valid && (w_sn_state != MESI_I) && (w_sn_tag_q == w_sn_tag);
    assign w_accept     = (r_fsm == S_IDLE) && pr_valid && !snoop_valid;
    assign w_sn_we      = w_sn_hit;
    assign w_sn_new     = snoop_rdx ? MESI_I : MESI_S;
    assign snoop_shared = w_sn_hit;
    assign snoop_flush  = w_sn_hit && ((w_sn_state == MESI_M) || (w_sn_state == MESI_E && !snoop_rdx));
    assign dbg_state    = (w_pr_tag_q == w_pr_tag) ? w_pr_state : MESI_I;
    // A remote writer stole our S copy before we won the bus: a full fill is needed.
    assign w_upg_kill   = (r_fsm == S_UPG) && r_bus_req && w_sn_hit && snoop_rdx && (snoop_addr == r_addr);

    assign pr_ready = r_pr_ready;
    assign bus_req  = r_bus_req;
    assign bus_cmd  = r_bus_cmd;
    assign bus_addr = r_bus_addr;

    always_comb begin
        w_ctl_we    = 1'b0;
        w_tag_we    = 1'b0;
        w_ctl_idx   = r_addr[IDX_W-1:0];
        w_ctl_state = MESI_I;
        case (r_fsm)
            S_IDLE: if (w_accept && w_pr_hit && pr_wr && w_pr_state != MESI_S) begin
                w_ctl_we    = 1'b1;
                w_ctl_idx   = w_pr_idx;
                w_ctl_state = MESI_M;
            end
            S_WB:   w_ctl_we = bus_done;
            S_FILL: begin
                w_ctl_we    = bus_done;
                w_tag_we    = bus_done;
                w_ctl_state = r_wr ? MESI_M : (shared_in ? MESI_S : MESI_E);
            end
            S_UPG: begin
                w_ctl_we    = bus_done;
                w_ctl_state = MESI_M;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fsm      <= S_IDLE;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_bus_req  <= 1'b0;
            r_bus_cmd  <= c_CMD_NONE;
            r_bus_addr <= '0;
            r_pr_ready <= 1'b0;
        end else begin
            r_pr_ready <= 1'b0;
            if (bus_gnt) r_bus_req <= 1'b0;
            case (r_fsm)
                S_IDLE: if (w_accept) begin
                    r_addr <= pr_addr;
                    r_wr   <= pr_wr;
                    if (w_pr_hit && (!pr_wr || w_pr_state != MESI_S)) begin
                        r_fsm      <= S_RESP;
                        r_pr_ready <= 1'b1;
                    end else if (w_pr_hit) begin
                        r_fsm      <= S_UPG;
                        r_bus_req  <= 1'b1;
                        r_bus_cmd  <= c_UPG_CMD;
                        r_bus_addr <= pr_addr;
                    end else if (w_pr_state == MESI_M) begin
                        r_fsm      <= S_WB;
                        r_bus_req  <= 1'b1;
                        r_bus_cmd  <= c_CMD_WB;
                        r_bus_addr <= {w_pr_tag_q, w_pr_idx};
                    end else begin
                        r_fsm      <= S_FILL;
                        r_bus_req  <= 1'b1;
                        r_bus_cmd  <= pr_wr ? c_CMD_BUSRDX : c_CMD_BUSRD;
                        r_bus_addr <= pr_addr;
                    end
                end
                S_WB: if (bus_done) begin
                    r_fsm      <= S_FILL;
                    r_bus_req  <= 1'b1;
                    r_bus_cmd  <= r_wr ? c_CMD_BUSRDX : c_CMD_BUSRD;
                    r_bus_addr <= r_addr;
                end
                S_FILL, S_UPG: begin
                    if (bus_done) begin
                        r_fsm      <= S_RESP;
                        r_pr_ready <= 1'b1;
                        r_bus_cmd  <= c_CMD_NONE;
                        r_bus_addr <= '0;
                    end else if (w_upg_kill) begin
                        r_fsm     <= S_FILL;
                        r_bus_cmd <= c_CMD_BUSRDX;
                    end
                end
                S_RESP:  r_fsm <= S_IDLE;
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mesi_multiline_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mesi_multiline_controller                                         |
// | Directed and random stimulus against a cache-state reference model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mesi_multiline_controller;

`ifdef MESI_UPGR_EN
    localparam int c_UPG_CMD = 3;
`else
    localparam int c_UPG_CMD = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pr_valid = 1'b0, pr_wr = 1'b0;
    logic [15:0] pr_addr = '0;
    logic        pr_ready, bus_req;
    logic        bus_gnt = 1'b0, bus_done = 1'b0, shared_in = 1'b0;
    logic [1:0]  bus_cmd, dbg_state;
    logic [15:0] bus_addr;
    logic        snoop_valid = 1'b0, snoop_rdx = 1'b0;
    logic [15:0] snoop_addr = '0;
    logic        snoop_shared, snoop_flush;

    mesi_multiline_controller #(.NUM_LINES(8), .ADDR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .pr_valid(pr_valid), .pr_wr(pr_wr), .pr_addr(pr_addr),
        .pr_ready(pr_ready), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_done(bus_done), .shared_in(shared_in),
        .snoop_valid(snoop_valid), .snoop_rdx(snoop_rdx), .snoop_addr(snoop_addr),
        .snoop_shared(snoop_shared), .snoop_flush(snoop_flush), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_state [8];   // 0=I 1=S 2=E 3=M
    int m_tag   [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_dbg(input int addr);
        int idx = addr % 8;
        return (m_state[idx] != 0 && m_tag[idx] == addr / 8) ? m_state[idx] : 0;
    endfunction

    task automatic bus_xfer(input bit sh);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_done  = 1'b1;
        shared_in = sh;
        @(negedge clk);
        bus_gnt   = 1'b0;
        bus_done  = 1'b0;
        shared_in = 1'b0;
    endtask

    task automatic do_req(input int addr, input bit wr, input bit sh, input string nm);
        int idx = addr % 8;
        int tg  = addr / 8;
        int q_cmd[$];
        int q_addr[$];
        bit hit = (m_state[idx] != 0) && (m_tag[idx] == tg);
        if (hit && (!wr || m_state[idx] != 1)) begin
            if (wr) m_state[idx] = 3;
        end else if (hit) begin
            q_cmd.push_back(c_UPG_CMD); q_addr.push_back(addr);
            m_state[idx] = 3;
        end else begin
            if (m_state[idx] == 3) begin
                q_cmd.push_back(3); q_addr.push_back(m_tag[idx] * 8 + idx);
            end
            q_cmd.push_back(wr ? 2 : 1); q_addr.push_back(addr);
            m_state[idx] = wr ? 3 : (sh ? 1 : 2);
            m_tag[idx]   = tg;
        end
        @(negedge clk);
        pr_valid = 1'b1; pr_wr = wr; pr_addr = 16'(addr);
        @(negedge clk);
        pr_valid = 1'b0;
        if (q_cmd.size() == 0) begin
            chk({nm, "_no_bus"}, bus_req, 0);
        end
        while (q_cmd.size() > 0) begin
            int w = 0;
            while (!bus_req && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!bus_req) begin
                chk({nm, "_req_timeout"}, bus_req, 1);
                return;
            end
            chk({nm, "_cmd"}, bus_cmd, q_cmd.pop_front());
            chk({nm, "_addr"}, bus_addr, q_addr.pop_front());
            bus_xfer(sh);
        end
        chk({nm, "_ready"}, pr_ready, 1);
        chk({nm, "_cmd_idle"}, bus_cmd, 0);
        @(negedge clk);
        chk({nm, "_ready_pulse"}, pr_ready, 0);
        chk({nm, "_state"}, dbg_state, exp_dbg(addr));
    endtask

    task automatic do_snoop(input int addr, input bit rdx, input string nm);
        int idx = addr % 8;
        bit hit = (m_state[idx] != 0) && (m_tag[idx] == addr / 8);
        bit fl  = hit && (m_state[idx] == 3 || (m_state[idx] == 2 && !rdx));
        @(negedge clk);
        snoop_valid = 1'b1; snoop_rdx = rdx; snoop_addr = 16'(addr);
        #1;
        chk({nm, "_shared"}, snoop_shared, hit);
        chk({nm, "_flush"}, snoop_flush, fl);
        if (hit) m_state[idx] = rdx ? 0 : 1;
        @(negedge clk);
        snoop_valid = 1'b0;
        pr_addr = 16'(addr);
        #1;
        chk({nm, "_state"}, dbg_state, exp_dbg(addr));
    endtask

    initial begin
        int old_tag [8];
        for (int i = 0; i < 8; i++) begin m_state[i] = 0; m_tag[i] = 0; end

        // Reset state
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_cmd", bus_cmd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_pr_ready", pr_ready, 0);
        chk("rst_dbg", dbg_state, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Cold read miss to E, then a silent read hit
        do_req(16'h0005, 0, 0, "rd_miss_e");
        do_req(16'h0005, 0, 0, "rd_hit");
        // Write hit in E: silent upgrade to M
        do_req(16'h0005, 1, 0, "wr_hit_e");
        // Conflict miss with a dirty victim: write-back then fill
        do_req(16'h000D, 0, 1, "evict_m");
        // S -> M via bus upgrade, then remote read demotes M to S
        do_req(16'h000D, 1, 0, "wr_hit_s");
        do_snoop(16'h000D, 0, "snp_rd_m");
        do_snoop(16'h0015, 1, "snp_other_tag");
        pr_addr = 16'h000D;
        #1;
        chk("snp_other_keep", dbg_state, exp_dbg(16'h000D));

        // Pending upgrade killed by a remote BusRdX before grant
        do_req(16'h0003, 0, 1, "fill_s");
        @(negedge clk);
        pr_valid = 1'b1; pr_wr = 1'b1; pr_addr = 16'h0003;
        @(negedge clk);
        pr_valid = 1'b0;
        chk("upg_req", bus_req, 1);
        chk("upg_cmd", bus_cmd, c_UPG_CMD);
        snoop_valid = 1'b1; snoop_rdx = 1'b1; snoop_addr = 16'h0003;
        #1;
        chk("upg_snoop_shared", snoop_shared, 1);
        @(negedge clk);
        snoop_valid = 1'b0;
        chk("upg_conv_req", bus_req, 1);
        chk("upg_conv_cmd", bus_cmd, 2);
        chk("upg_conv_addr", bus_addr, 16'h0003);
        bus_xfer(1);
        chk("upg_conv_ready", pr_ready, 1);
        m_state[3] = 3; m_tag[3] = 0;
        @(negedge clk);
        chk("upg_conv_state", dbg_state, 3);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            int a = int'($urandom_range(0, 3)) * 8 + int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) < 2)
                do_req(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_req");
            else
                do_snoop(a, 1'($urandom_range(0, 1)), "rnd_snp");
        end

        // Reset during FILL: make index 6 invalid first so the miss skips WB
        if (m_state[6] != 0) do_snoop(m_tag[6] * 8 + 6, 1, "pre_rst_inv");
        for (int i = 0; i < 8; i++) old_tag[i] = m_tag[i];
        @(negedge clk);
        pr_valid = 1'b1; pr_wr = 1'b0; pr_addr = 16'h003E;
        @(negedge clk);
        pr_valid = 1'b0;
        chk("fill_req", bus_req, 1);
        chk("fill_cmd", bus_cmd, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_cmd", bus_cmd, 0);
        chk("mid_rst_addr", bus_addr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_ready", pr_ready, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_ready", pr_ready, 0);
            chk("post_rst_req", bus_req, 0);
        end
        for (int i = 0; i < 8; i++) begin
            pr_addr = 16'(old_tag[i] * 8 + i);
            #1;
            chk("post_rst_line", dbg_state, 0);
            m_state[i] = 0;
        end
        do_req(16'h0005, 0, 0, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
